key_event_arbiter: RTL and testbench
====================================

Name: key_event_arbiter

Overview:
- Sits downstream of the per-key debounce blocks. Takes NUM_KEYS debounced key levels and turns level changes into press, release and long-press events.
- Events from all keys share a single valid/ready event channel. That channel feeds the UI/control FSM.
- The block keeps one pending event slot per key and grants the channel round-robin.

Parameters:
- NUM_KEYS, 4, number of debounced key inputs.
- IDX_BITS, 2, width of the key index; must satisfy 2^IDX_BITS >= NUM_KEYS.
- LONG_TIME, 12000000, cycles a key must stay pressed to raise a long-press event (1 s at 12 MHz); must be >= 2.
- CNT_BITS, 24, width of each per-key hold counter; must satisfy 2^CNT_BITS > LONG_TIME.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous active-high reset
- key_i  in  NUM_KEYS  debounced key levels, 1 = pressed, synchronous to sys_clk
- evt_valid  out  1  event present on the evt_* outputs
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready at a rising edge
- evt_key  out  IDX_BITS  index of the key that raised the event
- evt_type  out  2  01 = press, 10 = release, 11 = long-press; 00 never presented with evt_valid = 1
- pend_o  out  NUM_KEYS  per-key pending flag (slot non-empty)
- overflow_o  out  1  sticky flag: a pending event was overwritten before it was granted

Behaviour:
- Reset: sys_rst = 1 at an edge clears the following.
  - key_prev = 0, all hold counters = 0, all pending slots = 00, rr_ptr = NUM_KEYS-1.
  - evt_valid = 0, evt_key = 0, evt_type = 00, overflow_o = 0.
  - A mid-operation reset discards pending and presented events, with no handshake required.
  - A key already high when reset releases produces a press event, because key_prev = 0.
- Edge detect, per key i, at each edge:
  - key_prev[i] <= key_i[i].
  - rise (key_i[i] = 1, key_prev[i] = 0) -> slot[i] <= 01.
  - fall (key_i[i] = 0, key_prev[i] = 1) -> slot[i] <= 10.
- Hold counter, per key:
  - Counter = 0 while key_i[i] = 0.
  - While key_i[i] = 1 and counter < LONG_TIME-1, it increments.
  - At LONG_TIME-1 it saturates; exactly one long-press event per press.
  - At the edge where the counter becomes LONG_TIME-1, slot[i] <= 11.
  - Release resets the counter; the next press restarts from 0.
- Slot write conflicts:
  - New event while slot[i] != 00 and slot i is not being granted this edge -> overwrite, overflow_o <= 1.
  - New event on the same edge slot i is granted -> new event stored, no overflow.
  - Rise and long on the same key cannot coincide.
- Output register, two states:
  - EMPTY (evt_valid = 0) and FULL (evt_valid = 1).
  - A load is allowed at an edge when evt_valid = 0 or evt_ready = 1.
  - Load with any slot non-empty: select the first non-empty slot searching rr_ptr+1, rr_ptr+2, … modulo NUM_KEYS.
    - evt_key <= index, evt_type <= slot, evt_valid <= 1.
    - Clear that slot, rr_ptr <= index.
  - Load with no slot non-empty: evt_valid <= 0; evt_key and evt_type hold their values.
  - While evt_valid = 1 and evt_ready = 0, evt_key and evt_type are stable.
  - Back-to-back grants without a bubble are required when evt_ready stays high.
- Arbitration uses slot contents registered before the edge, so an event set at edge k is grantable at edge k+1 at the earliest.
- Latency: key_i first sampled high at edge k -> slot set at edge k -> evt_valid = 1 after edge k+1, if the output is free.
- pend_o[i] = (slot[i] != 00), registered slot state.
- Fairness: with all slots continuously refilled and evt_ready = 1, grants cycle 0,1,2,…,NUM_KEYS-1,0 with no key skipped.

Test Plan:
- Reset, then key_i = 0001 from edge 5, evt_ready = 1 -> evt_valid high after edge 6 with evt_key = 0, evt_type = 01; low after edge 7; pend_o = 0000.
- LONG_TIME = 8, key 2 held 20 cycles then released, evt_ready = 1 -> events (2,01), (2,11) exactly once ~8 cycles after the press, then (2,10); no second 11 event.
- key_i 0000 -> 1111 in one cycle, evt_ready = 1 -> four consecutive valid cycles with evt_key 0,1,2,3, all type 01; then rr_ptr = 3.
- evt_ready = 0, key 1 pressed then released before any grant -> overflow_o = 1; pend_o[1] = 1; after evt_ready = 1 the single event (1,10) is delivered; overflow_o stays 1 until reset.
- evt_valid = 1 with evt_ready = 0 for 10 cycles while key 3 toggles -> evt_key and evt_type unchanged throughout; the held event is accepted on the first ready cycle.
- Assert sys_rst while evt_valid = 1 and three slots are pending -> after the edge evt_valid = 0, pend_o = 0000, overflow_o = 0; keys held high regenerate press events after reset release.

Source files
------------

// File: rtl/key_event_arbiter_if.sv
// -----------------------------------------------------------------------------
// key_event_arbiter_if
// Purpose : valid/ready event channel carrying key events from the key event
//           arbiter to the UI/control FSM.
// Signals : evt_valid  event present on evt_key/evt_type
//           evt_ready  consumer accepts when evt_valid && evt_ready at an edge
//           evt_key    index of the key that raised the event
//           evt_type   01 press, 10 release, 11 long-press
// Modports: master (event producer), slave (event consumer)
// -----------------------------------------------------------------------------
interface key_event_arbiter_if #(
   parameter int IDX_BITS = 2
) ();
   logic                evt_valid;
   logic                evt_ready;
   logic [IDX_BITS-1:0] evt_key;
   logic [1:0]          evt_type;

   modport master (
      output evt_valid,
      output evt_key,
      output evt_type,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_key,
      input  evt_type,
      output evt_ready
   );
endinterface

// File: rtl/key_event_arbiter.sv
// -----------------------------------------------------------------------------
// key_event_arbiter
// Purpose : turns NUM_KEYS debounced key levels into press / release /
//           long-press events, holds one pending event slot per key and
//           grants a single valid/ready event channel round-robin.
// Ports   : sys_clk     system clock
//           sys_rst     synchronous active-high reset
//           key_i       debounced key levels, 1 = pressed
//           evt         event channel (master side)
//           pend_o      per-key pending flag (slot non-empty)
//           overflow_o  sticky: a pending event was overwritten before grant
// -----------------------------------------------------------------------------
module key_event_arbiter #(
   parameter int NUM_KEYS  = 4,
   parameter int IDX_BITS  = 2,
   parameter int LONG_TIME = 12000000,
   parameter int CNT_BITS  = 24
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [NUM_KEYS-1:0]  key_i,
   key_event_arbiter_if.master  evt,
   output logic [NUM_KEYS-1:0]  pend_o,
   output logic                 overflow_o
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

   localparam logic [1:0] EV_NONE    = 2'b00;
   localparam logic [1:0] EV_PRESS   = 2'b01;
   localparam logic [1:0] EV_RELEASE = 2'b10;
   localparam logic [1:0] EV_LONG    = 2'b11;

   // Counter value at which the long-press fires, and the value just before it.
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(LONG_TIME - 1);
   localparam logic [CNT_BITS-1:0] CNT_PRE  = CNT_BITS'(LONG_TIME - 2);
   localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [NUM_KEYS-1:0] key_prev_q;
   logic [CNT_BITS-1:0] cnt_q  [NUM_KEYS];
   logic [CNT_BITS-1:0] cnt_d  [NUM_KEYS];
   logic [1:0]          slot_q [NUM_KEYS];
   logic [1:0]          slot_d [NUM_KEYS];
   logic [1:0]          new_ev [NUM_KEYS];
   logic                ovf_q;
   logic                ovf_d;

   out_state_t          state_q;
   logic [IDX_BITS-1:0] key_q;
   logic [1:0]          type_q;
   logic [IDX_BITS-1:0] rr_ptr_q;

   logic [NUM_KEYS-1:0] pend;
   logic                load;
   logic                found;
   logic [IDX_BITS-1:0] sel_idx;
   logic [NUM_KEYS-1:0] grant_vec;

   // ---------------------------------------------------------------------------
   // Pending flags come straight from the registered slots
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < NUM_KEYS; i++) begin
         pend[i] = (slot_q[i] != EV_NONE);
      end
   end

   // ---------------------------------------------------------------------------
   // Round-robin search: first pending slot after rr_ptr, wrapping around.
   // The pointer itself is the last slot tried, so the key granted last time
   // has the lowest priority on the next grant.
   // ---------------------------------------------------------------------------
   always_comb begin
      load      = (state_q == ST_EMPTY) || evt.evt_ready;
      found     = 1'b0;
      sel_idx   = '0;
      grant_vec = '0;
      for (int off = 1; off <= NUM_KEYS; off++) begin
         if (!found && pend[IDX_BITS'((int'(rr_ptr_q) + off) % NUM_KEYS)]) begin
            found   = 1'b1;
            sel_idx = IDX_BITS'((int'(rr_ptr_q) + off) % NUM_KEYS);
         end
      end
      if (load && found) begin
         grant_vec[sel_idx] = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Edge detect, hold counters and slot update
   // ---------------------------------------------------------------------------
   always_comb begin
      ovf_d = ovf_q;
      for (int i = 0; i < NUM_KEYS; i++) begin
         // Counter runs only while pressed and saturates at LONG_TIME-1, so
         // the long-press compare below can match once per press.
         cnt_d[i] = '0;
         if (key_i[i]) begin
            cnt_d[i] = (cnt_q[i] < CNT_LAST) ? (cnt_q[i] + CNT_ONE) : cnt_q[i];
         end

         new_ev[i] = EV_NONE;
         if (key_i[i] && !key_prev_q[i]) begin
            new_ev[i] = EV_PRESS;
         end else if (!key_i[i] && key_prev_q[i]) begin
            new_ev[i] = EV_RELEASE;
         end
         if (key_i[i] && (cnt_q[i] == CNT_PRE)) begin
            new_ev[i] = EV_LONG;
         end

         slot_d[i] = slot_q[i];
         if (grant_vec[i]) begin
            slot_d[i] = EV_NONE;
         end
         // A slot being granted on this edge frees up, so writing into it is
         // not a loss.
         if (new_ev[i] != EV_NONE) begin
            slot_d[i] = new_ev[i];
            if (pend[i] && !grant_vec[i]) begin
               ovf_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         key_prev_q <= '0;
         ovf_q      <= 1'b0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_q[i]  <= '0;
            slot_q[i] <= EV_NONE;
         end
      end else begin
         key_prev_q <= key_i;
         ovf_q      <= ovf_d;
         for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_q[i]  <= cnt_d[i];
            slot_q[i] <= slot_d[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output register FSM: EMPTY / FULL with registered event fields
   // ---------------------------------------------------------------------------
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q  <= ST_EMPTY;
         key_q    <= '0;
         type_q   <= EV_NONE;
         rr_ptr_q <= IDX_BITS'(NUM_KEYS - 1);
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (found) begin
                  state_q  <= ST_FULL;
                  key_q    <= sel_idx;
                  type_q   <= slot_q[sel_idx];
                  rr_ptr_q <= sel_idx;
               end
            end
            ST_FULL: begin
               // Reloading in the accept cycle keeps grants back-to-back.
               if (evt.evt_ready) begin
                  if (found) begin
                     key_q    <= sel_idx;
                     type_q   <= slot_q[sel_idx];
                     rr_ptr_q <= sel_idx;
                  end else begin
                     state_q <= ST_EMPTY;
                  end
               end
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

   assign evt.evt_valid = (state_q == ST_FULL);
   assign evt.evt_key   = key_q;
   assign evt.evt_type  = type_q;
   assign pend_o        = pend;
   assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_key_event_arbiter
// Purpose : directed bench for key_event_arbiter with a short long-press time.
//           Expected events are queued when keys are driven and compared when
//           the DUT hands an event over; cycle-exact checks cover latency,
//           ordering, stability and reset behaviour.
// -----------------------------------------------------------------------------
module tb_key_event_arbiter;
   localparam int NK = 4;
   localparam int IB = 2;
   localparam int LT = 8;
   localparam int CB = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NK-1:0] key = '0;
   logic [NK-1:0] pend;
   logic          ovf;

   int total = 0;
   int bad   = 0;
   logic [3:0] sb[$];

   key_event_arbiter_if #(.IDX_BITS(IB)) ifc ();

   key_event_arbiter #(
      .NUM_KEYS (NK),
      .IDX_BITS (IB),
      .LONG_TIME(LT),
      .CNT_BITS (CB)
   ) dut (
      .sys_clk   (clk),
      .sys_rst   (rst),
      .key_i     (key),
      .evt       (ifc),
      .pend_o    (pend),
      .overflow_o(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [3:0] ev(input int k, input int t);
      return {k[1:0], t[1:0]};
   endfunction

   task automatic push(input int k, input int t);
      sb.push_back(ev(k, t));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(sb.size() == 0 && ifc.evt_valid == 1'b0) && n < 50) begin
         step();
         n++;
      end
      chk("drain", {31'd0, (sb.size() == 0 && ifc.evt_valid == 1'b0)}, 32'd1);
   endtask

   // Handshake monitor: every accepted event must be the oldest expected one.
   always @(negedge clk) begin
      if (!rst && ifc.evt_valid === 1'b1 && ifc.evt_ready === 1'b1) begin
         chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
         if (sb.size() > 0) begin
            chk("sb_event", {28'd0, ifc.evt_key, ifc.evt_type}, {28'd0, sb.pop_front()});
         end
      end
   end

   initial begin
      ifc.evt_ready = 1'b0;
      rst = 1'b1;
      key = '0;
      step(3);
      chk("rst_valid", ifc.evt_valid, 0);
      chk("rst_key",   ifc.evt_key,   0);
      chk("rst_type",  ifc.evt_type,  0);
      chk("rst_pend",  pend,          0);
      chk("rst_ovf",   ovf,           0);
      rst = 1'b0;
      ifc.evt_ready = 1'b1;
      step();

      // Single press: slot after first edge, event after second, gone after third
      key = 4'b0001;
      push(0, 1);
      step();
      chk("t1_pend", pend, 4'b0001);
      chk("t1_v0",   ifc.evt_valid, 0);
      step();
      chk("t1_valid", ifc.evt_valid, 1);
      chk("t1_key",   ifc.evt_key,   0);
      chk("t1_type",  ifc.evt_type,  1);
      chk("t1_pend0", pend, 4'b0000);
      step();
      chk("t1_drop", ifc.evt_valid, 0);
      key = 4'b0000;
      push(0, 2);
      wait_idle();

      // Long press on key 2: press after edge 2, long after edge 8, only once
      key = 4'b0100;
      push(2, 1);
      push(2, 3);
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 2) begin
            chk("t2_press_v", ifc.evt_valid, 1);
            chk("t2_press_t", ifc.evt_type, 1);
         end else if (i == 8) begin
            chk("t2_long_v", ifc.evt_valid, 1);
            chk("t2_long_t", ifc.evt_type, 3);
            chk("t2_long_k", ifc.evt_key, 2);
         end else begin
            chk("t2_idle", ifc.evt_valid, 0);
         end
      end
      key = 4'b0000;
      push(2, 2);
      wait_idle();

      // All keys at once after reset: grants 0,1,2,3 back-to-back
      rst = 1'b1;
      step();
      rst = 1'b0;
      key = 4'b1111;
      for (int k = 0; k < NK; k++) push(k, 1);
      for (int i = 1; i <= 6; i++) begin
         step();
         if (i == 1) chk("t3_pend", pend, 4'b1111);
         if (i >= 2 && i <= 5) begin
            chk("t3_valid", ifc.evt_valid, 1);
            chk("t3_key",   ifc.evt_key, i - 2);
         end else begin
            chk("t3_gap", ifc.evt_valid, 0);
         end
      end
      chk("t3_pend0", pend, 4'b0000);
      // rr_ptr ended at 3, so the releases must again start at key 0
      key = 4'b0000;
      for (int k = 0; k < NK; k++) push(k, 2);
      step();
      for (int k = 0; k < NK; k++) begin
         step();
         chk("t3_rel_key", ifc.evt_key, k);
         chk("t3_rel_type", ifc.evt_type, 2);
      end
      wait_idle();

      // Overflow: output held by key 0, key 1 pressed then released
      ifc.evt_ready = 1'b0;
      key = 4'b0001;
      push(0, 1);
      step(2);
      chk("t4_held", ifc.evt_valid, 1);
      key = 4'b0011;
      step();
      chk("t4_no_ovf", ovf, 0);
      key = 4'b0001;
      step();
      chk("t4_ovf",  ovf,  1);
      chk("t4_pend", pend, 4'b0010);
      push(1, 2);
      push(0, 2);
      key = 4'b0000;
      ifc.evt_ready = 1'b1;
      wait_idle();
      chk("t4_ovf_sticky", ovf, 1);

      // Held event stays stable while key 3 toggles
      ifc.evt_ready = 1'b0;
      key = 4'b0001;
      push(0, 1);
      step();
      key = 4'b0000;
      step();
      for (int j = 0; j < 10; j++) begin
         key[3] = (j % 2 == 0);
         step();
         chk("t5_hold_v", ifc.evt_valid, 1);
         chk("t5_hold_k", ifc.evt_key,   0);
         chk("t5_hold_t", ifc.evt_type,  1);
      end
      push(3, 2);
      push(0, 2);
      ifc.evt_ready = 1'b1;
      step();
      chk("t5_next_k", ifc.evt_key,  3);
      chk("t5_next_t", ifc.evt_type, 2);
      wait_idle();

      // Reset with output full and three slots pending
      ifc.evt_ready = 1'b0;
      key = 4'b1111;
      step(2);
      chk("t6_full", ifc.evt_valid, 1);
      chk("t6_key",  ifc.evt_key,   1);
      chk("t6_pend", pend, 4'b1101);
      rst = 1'b1;
      step();
      chk("t6_rst_valid", ifc.evt_valid, 0);
      chk("t6_rst_pend",  pend, 4'b0000);
      chk("t6_rst_ovf",   ovf,  0);
      chk("t6_rst_type",  ifc.evt_type, 0);
      rst = 1'b0;
      ifc.evt_ready = 1'b1;
      for (int k = 0; k < NK; k++) push(k, 1);
      for (int i = 1; i <= 5; i++) begin
         step();
         if (i >= 2) chk("t6_regen_key", ifc.evt_key, i - 2);
      end
      key = 4'b0000;
      for (int k = 0; k < NK; k++) push(k, 2);
      wait_idle();

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
